// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller wrapped around a simple dual-port
// RAM with a 1-cycle registered read. A 2-entry output buffer absorbs the read
// latency so a continuous stream runs at one word per cycle.
module ram_fifo_ctrl #(
    parameter int WIDTH   = 8,
    parameter int WIDTHAD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [WIDTHAD+1:0] count,
    output logic [WIDTHAD-1:0] ram_wraddress,
    output logic               ram_wren,
    output logic [WIDTH-1:0]   ram_data,
    output logic [WIDTHAD-1:0] ram_rdaddress,
    input  logic [WIDTH-1:0]   ram_q
);

    localparam int DEPTH = 2 ** WIDTHAD;
    localparam logic [WIDTHAD:0] DEPTH_V = (WIDTHAD + 1)'(DEPTH);

    // Pointers and occupancy of the RAM portion
    logic [WIDTHAD-1:0] wr_ptr_r;
    logic [WIDTHAD-1:0] rd_ptr_r;
    logic [WIDTHAD:0]   ram_count_r;
    logic [WIDTHAD:0]   ram_count_next_s;
    logic               inflight_r;

    // 2-entry output buffer; head_r is always the word presented on out_data
    logic [1:0]         buf_count_r;
    logic [1:0]         buf_count_next_s;
    logic [WIDTH-1:0]   head_r;
    logic [WIDTH-1:0]   head_next_s;
    logic [WIDTH-1:0]   tail_r;
    logic [WIDTH-1:0]   tail_next_s;

    // Registered copies of the externally visible status
    logic               out_valid_r;
    logic [WIDTHAD+1:0] count_r;

    logic               push_s;
    logic               pop_s;
    logic               issue_s;
    logic [2:0]         pending_s;

    // Handshakes, RAM port drive and read-issue decision
    always_comb begin
        in_ready      = !reset && (ram_count_r < DEPTH_V);
        push_s        = in_valid && in_ready;
        pop_s         = out_valid_r && out_ready;
        ram_wren      = push_s;
        ram_wraddress = wr_ptr_r;
        ram_data      = in_data;
        ram_rdaddress = rd_ptr_r;
        out_valid     = out_valid_r;
        out_data      = head_r;
        count         = count_r;
        // Words already headed for the buffer; only issue when a slot is
        // guaranteed once the pending read lands (pop frees one this cycle).
        pending_s     = {1'b0, buf_count_r} + {2'b00, inflight_r};
        issue_s       = (ram_count_r != {(WIDTHAD + 1){1'b0}}) &&
                        (pending_s < (3'd2 + {2'b00, pop_s}));
        ram_count_next_s = ram_count_r
                         + {{WIDTHAD{1'b0}}, push_s}
                         - {{WIDTHAD{1'b0}}, issue_s};
    end

    // Output buffer next state: capture of ram_q and/or pop of the head
    always_comb begin
        buf_count_next_s = buf_count_r;
        head_next_s      = head_r;
        tail_next_s      = tail_r;
        case ({inflight_r, pop_s})
            2'b10: begin
                buf_count_next_s = buf_count_r + 2'd1;
                case (buf_count_r)
                    2'd0:    head_next_s = ram_q;
                    2'd1:    tail_next_s = ram_q;
                    default: tail_next_s = tail_r;
                endcase
            end
            2'b01: begin
                buf_count_next_s = buf_count_r - 2'd1;
                head_next_s      = tail_r;
            end
            2'b11: begin
                case (buf_count_r)
                    2'd1: head_next_s = ram_q;
                    2'd2: begin
                        head_next_s = tail_r;
                        tail_next_s = ram_q;
                    end
                    default: head_next_s = head_r;
                endcase
            end
            default: begin
                buf_count_next_s = buf_count_r;
            end
        endcase
    end

    // State update; reset drops everything including a read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {WIDTHAD{1'b0}};
            rd_ptr_r    <= {WIDTHAD{1'b0}};
            ram_count_r <= {(WIDTHAD + 1){1'b0}};
            inflight_r  <= 1'b0;
            buf_count_r <= 2'd0;
            head_r      <= {WIDTH{1'b0}};
            tail_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            count_r     <= {(WIDTHAD + 2){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(WIDTHAD - 1){1'b0}}, 1'b1};
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + {{(WIDTHAD - 1){1'b0}}, 1'b1};
            end
            ram_count_r <= ram_count_next_s;
            inflight_r  <= issue_s;
            buf_count_r <= buf_count_next_s;
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            out_valid_r <= (buf_count_next_s != 2'd0);
            count_r     <= count_r
                         + {{(WIDTHAD + 1){1'b0}}, push_s}
                         - {{(WIDTHAD + 1){1'b0}}, pop_s};
        end
    end

    // A landing read must always find a free buffer slot
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inflight_r && (buf_count_r == 2'd2) && !pop_s));

    // Total occupancy never exceeds RAM depth plus the two buffer slots
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        (count_r <= (WIDTHAD + 2)'(DEPTH + 2)));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM plus a scoreboard
// queue holding every accepted word until the DUT emits it.
module tb_ram_fifo_ctrl;

    localparam int WIDTH   = 8;
    localparam int WIDTHAD = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [WIDTHAD+1:0] count;
    logic [WIDTHAD-1:0] ram_wraddress;
    logic               ram_wren;
    logic [WIDTH-1:0]   ram_data;
    logic [WIDTHAD-1:0] ram_rdaddress;
    logic [WIDTH-1:0]   ram_q;

    logic [WIDTH-1:0]   mem [0:(2**WIDTHAD)-1];

    int vectors = 0;
    int errors  = 0;
    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic             pushed;
        logic             popped;
        logic             ov;
        logic             ir;
        logic             wren;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] data;
        logic [WIDTHAD+1:0] cnt;
        int               held;
    } obs_t;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_wraddress(ram_wraddress), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
    );

    // Simple dual-port RAM: registered read, old data on collision
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    // Drive one cycle, sample mid-cycle, record accepted words in the scoreboard
    task automatic do_cycle(input logic vi, input logic [WIDTH-1:0] d,
                            input logic ordy, output obs_t o);
        in_valid  = vi;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        o.pushed = in_valid && in_ready;
        o.popped = out_valid && out_ready;
        o.ov     = out_valid;
        o.ir     = in_ready;
        o.wren   = ram_wren;
        o.wdata  = ram_data;
        o.data   = out_data;
        o.cnt    = count;
        o.held   = sb.size();
        if (o.pushed) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, want 0", in_ready); end
        vectors++;
        if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b, want 0", ram_wren); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        vectors++;
        if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d, want 0", count); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, want 1", in_ready); end
        @(posedge clk); #1;
        sb.delete();
    endtask

    task automatic test_single();
        obs_t o;
        logic [WIDTH-1:0] exp;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            do_cycle(k == 0, 8'hA5, 1'b1, o);
            if (k == 0) begin
                vectors++;
                if (o.wren !== 1'b1 || o.wdata !== 8'hA5) begin
                    errors++; $display("FAIL single_write: wren %b data %h, want 1 a5", o.wren, o.wdata);
                end
            end
            vectors++;
            if (o.ov !== (k == 3)) begin errors++; $display("FAIL single_valid c%0d: got %b, want %b", k, o.ov, (k == 3)); end
            vectors++;
            if (o.cnt !== ((k >= 1 && k <= 3) ? 6'd1 : 6'd0)) begin
                errors++; $display("FAIL single_count c%0d: got %0d", k, o.cnt);
            end
            if (o.popped) begin
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL single_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL single_data: got %h, want %h", o.data, exp); end
                end
            end
        end
    endtask

    task automatic test_fill();
        obs_t o;
        logic [WIDTH-1:0] exp;
        int nxt = 0;
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            do_cycle(nxt < 20, 8'(nxt), 1'b0, o);
            if (o.pushed) nxt++;
        end
        vectors++;
        if (nxt != 18) begin errors++; $display("FAIL fill_accepted: got %0d, want 18", nxt); end
        vectors++;
        if (o.ir !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b, want 0", o.ir); end
        vectors++;
        if (o.cnt !== 6'd18) begin errors++; $display("FAIL fill_count: got %0d, want 18", o.cnt); end
        for (int k = 0; k < 25; k++) begin
            do_cycle(1'b0, 8'h00, 1'b1, o);
            vectors++;
            if (o.popped !== (k < 18)) begin errors++; $display("FAIL fill_drain_valid c%0d: got %b, want %b", k, o.popped, (k < 18)); end
            if (o.popped) begin
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL fill_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL fill_data: got %h, want %h", o.data, exp); end
                end
            end
        end
        vectors++;
        if (o.cnt !== 6'd0) begin errors++; $display("FAIL fill_final_count: got %0d, want 0", o.cnt); end
    endtask

    task automatic test_stream();
        obs_t o;
        logic [WIDTH-1:0] exp;
        int pops = 0;
        apply_reset();
        for (int k = 0; k < 110; k++) begin
            do_cycle(k < 100, 8'(k), 1'b1, o);
            if (k >= 3 && k < 100) begin
                vectors++;
                if (o.ov !== 1'b1 || o.cnt !== 6'd3) begin
                    errors++; $display("FAIL stream_steady c%0d: valid %b count %0d, want 1 3", k, o.ov, o.cnt);
                end
            end
            if (o.popped) begin
                pops++;
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL stream_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL stream_data: got %h, want %h", o.data, exp); end
                end
            end
        end
        vectors++;
        if (pops != 100) begin errors++; $display("FAIL stream_total: got %0d words, want 100", pops); end
    endtask

    task automatic test_wrap();
        obs_t o;
        logic [WIDTH-1:0] exp;
        int sent = 0;
        int got  = 0;
        apply_reset();
        for (int k = 0; k < 3000 && got < 50; k++) begin
            do_cycle(sent < 50 && $urandom_range(0, 2) != 0, 8'(sent * 7 + 3),
                     1'($urandom_range(0, 2) != 0), o);
            if (o.pushed) sent++;
            vectors++;
            if (o.cnt !== 6'(o.held)) begin errors++; $display("FAIL wrap_count: got %0d, want %0d", o.cnt, o.held); end
            if (o.popped) begin
                got++;
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL wrap_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL wrap_data: got %h, want %h", o.data, exp); end
                end
            end
        end
        vectors++;
        if (got != 50) begin errors++; $display("FAIL wrap_total: got %0d words, want 50", got); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] prev_data = 8'h00;
        logic prev_stall = 1'b0;
        logic ordy;
        apply_reset();
        for (int k = 0; k < 2100; k++) begin
            ordy = (k >= 2000) ? 1'b1 : 1'($urandom_range(0, 1));
            do_cycle((k < 2000) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom_range(0, 255)), ordy, o);
            vectors++;
            if (o.cnt !== 6'(o.held)) begin errors++; $display("FAIL bp_count c%0d: got %0d, want %0d", k, o.cnt, o.held); end
            if (prev_stall) begin
                vectors++;
                if (o.ov !== 1'b1 || o.data !== prev_data) begin
                    errors++; $display("FAIL bp_stable c%0d: valid %b data %h, want 1 %h", k, o.ov, o.data, prev_data);
                end
            end
            if (o.popped) begin
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL bp_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL bp_data: got %h, want %h", o.data, exp); end
                end
            end
            prev_stall = o.ov && !ordy;
            prev_data  = o.data;
        end
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left, want 0", sb.size()); end
    endtask

    task automatic test_reset_midop();
        obs_t o;
        logic [WIDTH-1:0] exp;
        apply_reset();
        for (int k = 0; k < 10; k++) do_cycle(1'b1, 8'(8'h40 + k), 1'b0, o);
        do_cycle(1'b1, 8'h4A, 1'b1, o);
        vectors++;
        if (o.popped !== 1'b1) begin errors++; $display("FAIL midop_pop: got %b, want 1", o.popped); end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 6'd10) begin errors++; $display("FAIL midop_precount: got %0d, want 10", count); end
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            do_cycle(k == 0, 8'h3C, 1'b1, o);
            if (k == 0) begin
                vectors++;
                if (o.ov !== 1'b0 || o.cnt !== 6'd0 || o.ir !== 1'b1) begin
                    errors++; $display("FAIL midop_after_reset: valid %b count %0d ready %b, want 0 0 1", o.ov, o.cnt, o.ir);
                end
            end
            vectors++;
            if (o.ov !== (k == 3)) begin errors++; $display("FAIL midop_valid c%0d: got %b, want %b", k, o.ov, (k == 3)); end
            if (o.popped) begin
                vectors++;
                if (sb.size() == 0) begin errors++; $display("FAIL midop_data: got %h, want no word", o.data); end
                else begin
                    exp = sb.pop_front();
                    if (o.data !== exp) begin errors++; $display("FAIL midop_data: got %h, want %h", o.data, exp); end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_wrap();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
